// File: rtl/image_tx_if.sv
// Pixel-source stream into image_tx: packed 16-bit lanes (12-bit pixel plus 4-bit marker nibble)
// with a valid/ready handshake.
interface image_tx_if #(
  parameter int LANES = 8
);
  logic                 s_valid;
  logic                 s_ready;
  logic [LANES*16-1:0]  s_data;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/image_tx.sv
// EDS link transmitter: frames 16-bit pixel beats into a continuous per-lane 12-bit word stream.
// Optional build macro EDS_TX_CLIP_EN keeps DATA pixels off the 12'hFFF / 12'h000 sync codes.
module image_tx #(
  parameter int lvds_pairs  = 8,
  parameter int LINE_BEATS  = 256,
  parameter int GAP_BEATS   = 4,
  parameter int TRAIN_BEATS = 1024
) (
  input  logic                     clk_txg,
  input  logic                     rst_tx,
  input  logic                     eds_power_en,
  input  logic                     tx_en,
  input  logic [11:0]              training_word,
  input  logic                     cmd_start_training,
  image_tx_if.slave                s_if,
  output logic [lvds_pairs*12-1:0] tx_data,
  output logic                     tx_lval,
  output logic                     training_busy,
  output logic                     marker_err,
  output logic                     underrun_err,
  output logic [15:0]              line_cnt
);

  typedef enum logic [2:0] {
    ST_OFF, ST_IDLE, ST_TRAIN, ST_SOL, ST_DATA, ST_EOL, ST_GAP
  } state_t;

  localparam int W = lvds_pairs * 12;

  state_t          r_state;
  logic [15:0]     r_cnt;
  logic            r_pwr_p0, r_pwr_p1;
  logic            r_en_p0, r_en_p1;
  logic            r_train_pend;
  logic            r_s_ready;
  logic [W-1:0]    r_tx_data;
  logic            r_tx_lval;
  logic            r_busy;
  logic            r_marker_err;
  logic            r_underrun_err;
  logic [15:0]     r_line_cnt;

  logic [W-1:0]    w_pix;
  logic            w_mark_bad;
  logic [W-1:0]    w_train;

  function automatic logic [11:0] f_clip(input logic [11:0] p);
`ifdef EDS_TX_CLIP_EN
    if (p == 12'hFFF)      return 12'hFFE;
    else if (p == 12'h000) return 12'h001;
    else                   return p;
`else
    return p;
`endif
  endfunction

  assign w_train = {lvds_pairs{training_word}};

  // Lane unpacking and marker check; lane 0 of beat 0 carries the line-start nibble.
  always_comb begin
    w_pix      = '0;
    w_mark_bad = 1'b0;
    for (int k = 0; k < lvds_pairs; k++) begin
      w_pix[12*k +: 12] = f_clip(s_if.s_data[16*k +: 12]);
      if (k == 0 && r_cnt == 16'd0)
        w_mark_bad = w_mark_bad | (s_if.s_data[16*k+12 +: 4] != 4'hF);
      else
        w_mark_bad = w_mark_bad | (s_if.s_data[16*k+12 +: 4] != 4'h0);
    end
  end

  always_ff @(posedge clk_txg or posedge rst_tx) begin
    if (rst_tx) begin
      r_state        <= ST_OFF;
      r_cnt          <= '0;
      r_pwr_p0       <= 1'b0;
      r_pwr_p1       <= 1'b0;
      r_en_p0        <= 1'b0;
      r_en_p1        <= 1'b0;
      r_train_pend   <= 1'b0;
      r_s_ready      <= 1'b0;
      r_tx_data      <= '0;
      r_tx_lval      <= 1'b0;
      r_busy         <= 1'b0;
      r_marker_err   <= 1'b0;
      r_underrun_err <= 1'b0;
      r_line_cnt     <= '0;
    end else begin
      r_pwr_p0 <= eds_power_en;
      r_pwr_p1 <= r_pwr_p0;
      r_en_p0  <= tx_en;
      r_en_p1  <= r_en_p0;

      if (!r_pwr_p1) begin
        // Power-off wins over everything; counters and sticky errors are held.
        r_state      <= ST_OFF;
        r_cnt        <= '0;
        r_tx_data    <= '0;
        r_tx_lval    <= 1'b0;
        r_s_ready    <= 1'b0;
        r_busy       <= 1'b0;
        r_train_pend <= 1'b0;
      end else begin
        r_tx_lval <= 1'b0;
        r_busy    <= 1'b0;
        case (r_state)
          ST_OFF: begin
            r_tx_data <= '0;
            r_cnt     <= '0;
            r_state   <= ST_IDLE;
          end
          ST_IDLE: begin
            r_tx_data <= w_train;
            r_cnt     <= '0;
            if (r_train_pend) begin
              r_train_pend <= 1'b0;
              r_state      <= ST_TRAIN;
            end else if (r_en_p1 && s_if.s_valid) begin
              r_state <= ST_SOL;
            end
          end
          ST_TRAIN: begin
            r_tx_data <= w_train;
            r_busy    <= 1'b1;
            if (r_cnt == 16'(TRAIN_BEATS - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          ST_SOL: begin
            case (r_cnt)
              16'd0:   r_tx_data <= {lvds_pairs{12'hFFF}};
              16'd1:   r_tx_data <= {lvds_pairs{12'h000}};
              default: r_tx_data <= {lvds_pairs{12'hAB0}};
            endcase
            if (r_cnt == 16'd2) begin
              r_cnt     <= '0;
              r_s_ready <= 1'b1;
              r_state   <= ST_DATA;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          ST_DATA: begin
            // Fixed-length line: a missing beat becomes a fill word rather than a stall.
            r_tx_lval <= 1'b1;
            if (s_if.s_valid && r_s_ready) begin
              r_tx_data <= w_pix;
              if (w_mark_bad) r_marker_err <= 1'b1;
            end else begin
              r_tx_data      <= {lvds_pairs{12'h001}};
              r_underrun_err <= 1'b1;
            end
            if (r_cnt == 16'(LINE_BEATS - 1)) begin
              r_cnt     <= '0;
              r_s_ready <= 1'b0;
              r_state   <= ST_EOL;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          ST_EOL: begin
            case (r_cnt)
              16'd0:   r_tx_data <= {lvds_pairs{12'hFFF}};
              16'd1:   r_tx_data <= {lvds_pairs{12'h000}};
              default: r_tx_data <= {lvds_pairs{12'hB60}};
            endcase
            if (r_cnt == 16'd2) begin
              r_cnt      <= '0;
              r_line_cnt <= r_line_cnt + 16'd1;
              r_state    <= ST_GAP;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          ST_GAP: begin
            r_tx_data <= w_train;
            if (r_cnt == 16'(GAP_BEATS - 1)) begin
              r_cnt   <= '0;
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
          default: begin
            r_tx_data <= '0;
            r_cnt     <= '0;
            r_s_ready <= 1'b0;
            r_state   <= ST_OFF;
          end
        endcase
        if (cmd_start_training) r_train_pend <= 1'b1;
      end
    end
  end

  assign s_if.s_ready  = r_s_ready;
  assign tx_data       = r_tx_data;
  assign tx_lval       = r_tx_lval;
  assign training_busy = r_busy;
  assign marker_err    = r_marker_err;
  assign underrun_err  = r_underrun_err;
  assign line_cnt      = r_line_cnt;

endmodule

// File: tb/tb_image_tx.sv
// Directed bench for image_tx: idle pattern, framed lines, underrun fill, clipping,
// marker errors and training with a mid-burst power drop.
module tb_image_tx;
  localparam int NL  = 8;
  localparam int LB  = 256;
  localparam int CAP = 266;

  logic            clk = 1'b0;
  logic            rst;
  logic            eds_power_en;
  logic            tx_en;
  logic [11:0]     training_word;
  logic            cmd;
  logic [NL*12-1:0] tx_data;
  logic            tx_lval;
  logic            training_busy;
  logic            marker_err;
  logic            underrun_err;
  logic [15:0]     line_cnt;

  image_tx_if #(.LANES(NL)) sif ();

  image_tx #(.lvds_pairs(NL), .LINE_BEATS(LB), .GAP_BEATS(4), .TRAIN_BEATS(1024)) dut (
    .clk_txg            (clk),
    .rst_tx             (rst),
    .eds_power_en       (eds_power_en),
    .tx_en              (tx_en),
    .training_word      (training_word),
    .cmd_start_training (cmd),
    .s_if               (sif),
    .tx_data            (tx_data),
    .tx_lval            (tx_lval),
    .training_busy      (training_busy),
    .marker_err         (marker_err),
    .underrun_err       (underrun_err),
    .line_cnt           (line_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [NL*12-1:0] cap_data [CAP];
  logic             cap_lval [CAP];

  function automatic logic [11:0] pat_pix(int b, int k);
    return 12'(b * 8 + k + 16);
  endfunction

  function automatic logic [NL*16-1:0] beat_data(int b, logic [11:0] l3_pix,
                                                 logic [3:0] b0_nib, int bad_beat);
    logic [NL*16-1:0] d;
    logic [11:0] p;
    logic [3:0]  n;
    d = '0;
    for (int k = 0; k < NL; k++) begin
      p = pat_pix(b, k);
      n = 4'h0;
      if (k == 0 && b == 0) n = b0_nib;
      if (k == 2 && b == bad_beat) n = 4'h1;
      if (k == 3 && b == 7 && l3_pix != 12'h000) p = l3_pix;
      d[16*k +: 16] = {n, p};
    end
    return d;
  endfunction

  function automatic logic [NL*12-1:0] exp_beat(int b, logic [11:0] l3_exp);
    logic [NL*12-1:0] d;
    for (int k = 0; k < NL; k++) d[12*k +: 12] = pat_pix(b, k);
    if (b == 7 && l3_exp != 12'h000) d[12*3 +: 12] = l3_exp;
    return d;
  endfunction

  // Plays one source line and captures CAP output words starting at the SOL FFF word.
  task automatic drive_line(input int ul_lo, input int ul_hi, input logic [11:0] l3_pix,
                            input logic [3:0] b0_nib, input int bad_beat, input int cmd_beat,
                            output bit ok);
    int b;
    int n;
    bit started;
    b = 0; n = 0; started = 0;
    sif.s_valid = 1'b1;
    sif.s_data  = beat_data(0, l3_pix, b0_nib, bad_beat);
    for (int cyc = 0; cyc < 3000 && n < CAP; cyc++) begin
      @(posedge clk); #1;
      if (!started && tx_data[11:0] == 12'hFFF) started = 1;
      if (started) begin
        cap_data[n] = tx_data;
        cap_lval[n] = tx_lval;
        n++;
      end
      cmd = 1'b0;
      if (sif.s_ready) begin
        if (b == cmd_beat) cmd = 1'b1;
        sif.s_valid = !(b >= ul_lo && b <= ul_hi);
        sif.s_data  = beat_data(b, l3_pix, b0_nib, bad_beat);
        b++;
      end else if (b >= LB) begin
        sif.s_valid = 1'b0;
      end
    end
    sif.s_valid = 1'b0;
    cmd = 1'b0;
    ok = (n == CAP);
  endtask

  task automatic test_reset();
    rst = 1'b1; eds_power_en = 1'b0; tx_en = 1'b0; training_word = 12'h3A5; cmd = 1'b0;
    sif.s_valid = 1'b0; sif.s_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (tx_data !== '0 || tx_lval !== 1'b0 || sif.s_ready !== 1'b0 || training_busy !== 1'b0) begin
      errors++; $display("FAIL reset_outputs: data=%h lval=%b rdy=%b busy=%b, want all zero",
                         tx_data, tx_lval, sif.s_ready, training_busy);
    end
    checks++;
    if (marker_err !== 1'b0 || underrun_err !== 1'b0 || line_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_status: merr=%b uerr=%b lines=%0d, want 0/0/0",
                         marker_err, underrun_err, line_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic test_idle();
    eds_power_en = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if (tx_data !== {NL{12'h3A5}} || tx_lval !== 1'b0) begin
      errors++; $display("FAIL idle_word: data=%h lval=%b, want all lanes 3A5 lval 0", tx_data, tx_lval);
    end
    checks++;
    if (sif.s_ready !== 1'b0) begin
      errors++; $display("FAIL idle_ready: got %b want 0", sif.s_ready);
    end
    training_word = 12'h5C3;
    @(posedge clk); #1;
    checks++;
    if (tx_data !== {NL{12'h5C3}}) begin
      errors++; $display("FAIL idle_tw_change: data=%h want lanes 5C3", tx_data);
    end
    training_word = 12'h3A5;
    @(posedge clk); #1;
  endtask

  task automatic test_line();
    bit ok;
    tx_en = 1'b1;
    drive_line(1000, 1000, 12'h000, 4'hF, -1, -1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL line_timeout: no SOL seen, want a framed line"); end
    checks++;
    if (cap_data[0] !== {NL{12'hFFF}} || cap_data[1] !== {NL{12'h000}} || cap_data[2] !== {NL{12'hAB0}}) begin
      errors++; $display("FAIL line_sol: %h %h %h, want FFF/000/AB0", cap_data[0][11:0], cap_data[1][11:0], cap_data[2][11:0]);
    end
    for (int b = 0; b < LB; b++) begin
      checks++;
      if (cap_data[3+b] !== exp_beat(b, 12'h000) || cap_lval[3+b] !== 1'b1) begin
        errors++; $display("FAIL line_data beat %0d: got %h lval=%b want %h lval=1",
                           b, cap_data[3+b], cap_lval[3+b], exp_beat(b, 12'h000));
      end
    end
    checks++;
    if (cap_data[259] !== {NL{12'hFFF}} || cap_data[260] !== {NL{12'h000}} || cap_data[261] !== {NL{12'hB60}}
        || cap_lval[259] !== 1'b0 || cap_lval[2] !== 1'b0) begin
      errors++; $display("FAIL line_eol: %h %h %h lval=%b, want FFF/000/B60 lval=0",
                         cap_data[259][11:0], cap_data[260][11:0], cap_data[261][11:0], cap_lval[259]);
    end
    for (int g = 262; g < CAP; g++) begin
      checks++;
      if (cap_data[g] !== {NL{12'h3A5}} || cap_lval[g] !== 1'b0) begin
        errors++; $display("FAIL line_gap word %0d: got %h want lanes 3A5", g, cap_data[g]);
      end
    end
    checks++;
    if (line_cnt !== 16'd1 || marker_err !== 1'b0 || underrun_err !== 1'b0) begin
      errors++; $display("FAIL line_status: lines=%0d merr=%b uerr=%b, want 1/0/0", line_cnt, marker_err, underrun_err);
    end
  endtask

  task automatic test_underrun();
    bit ok;
    drive_line(10, 12, 12'h000, 4'hF, -1, -1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL underrun_timeout: no SOL seen, want a framed line"); end
    for (int b = 9; b <= 13; b++) begin
      checks++;
      if (b >= 10 && b <= 12) begin
        if (cap_data[3+b] !== {NL{12'h001}} || cap_lval[3+b] !== 1'b1) begin
          errors++; $display("FAIL underrun_fill beat %0d: got %h lval=%b want lanes 001 lval=1",
                             b, cap_data[3+b], cap_lval[3+b]);
        end
      end else if (cap_data[3+b] !== exp_beat(b, 12'h000)) begin
        errors++; $display("FAIL underrun_neighbour beat %0d: got %h want %h", b, cap_data[3+b], exp_beat(b, 12'h000));
      end
    end
    checks++;
    if (cap_data[258] !== exp_beat(255, 12'h000) || cap_data[259] !== {NL{12'hFFF}} || cap_data[261] !== {NL{12'hB60}}) begin
      errors++; $display("FAIL underrun_eol_pos: w258=%h w259=%h w261=%h, want last pixel/FFF/B60",
                         cap_data[258][11:0], cap_data[259][11:0], cap_data[261][11:0]);
    end
    checks++;
    if (underrun_err !== 1'b1 || marker_err !== 1'b0 || line_cnt !== 16'd2) begin
      errors++; $display("FAIL underrun_status: uerr=%b merr=%b lines=%0d, want 1/0/2", underrun_err, marker_err, line_cnt);
    end
  endtask

  task automatic test_clip();
    bit ok;
    logic [11:0] l3_exp;
`ifdef EDS_TX_CLIP_EN
    l3_exp = 12'hFFE;
`else
    l3_exp = 12'hFFF;
`endif
    drive_line(1000, 1000, 12'hFFF, 4'hF, -1, -1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL clip_timeout: no SOL seen, want a framed line"); end
    checks++;
    if (cap_data[10][12*3 +: 12] !== l3_exp) begin
      errors++; $display("FAIL clip_lane3: got %h want %h", cap_data[10][12*3 +: 12], l3_exp);
    end
    checks++;
    if (cap_data[10] !== exp_beat(7, l3_exp)) begin
      errors++; $display("FAIL clip_beat7: got %h want %h", cap_data[10], exp_beat(7, l3_exp));
    end
    checks++;
    if (marker_err !== 1'b0 || line_cnt !== 16'd3) begin
      errors++; $display("FAIL clip_status: merr=%b lines=%0d, want 0/3", marker_err, line_cnt);
    end
  endtask

  task automatic test_marker();
    bit ok;
    drive_line(1000, 1000, 12'h000, 4'hF, 5, -1, ok);
    checks++;
    if (!ok) begin errors++; $display("FAIL marker_timeout: no SOL seen, want a framed line"); end
    checks++;
    if (marker_err !== 1'b1) begin
      errors++; $display("FAIL marker_flag: got %b want 1", marker_err);
    end
    checks++;
    if (cap_data[8] !== exp_beat(5, 12'h000) || cap_lval[8] !== 1'b1) begin
      errors++; $display("FAIL marker_data: got %h want %h", cap_data[8], exp_beat(5, 12'h000));
    end
    checks++;
    if (line_cnt !== 16'd4) begin
      errors++; $display("FAIL marker_lines: got %0d want 4", line_cnt);
    end
  endtask

  task automatic test_training_power();
    bit ok;
    bit seen;
    drive_line(1000, 1000, 12'h000, 4'hF, -1, 50, ok);
    checks++;
    if (!ok || cap_data[261] !== {NL{12'hB60}} || line_cnt !== 16'd5) begin
      errors++; $display("FAIL train_line_done: ok=%b w261=%h lines=%0d, want 1/B60/5",
                         ok, cap_data[261][11:0], line_cnt);
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk); #1;
      if (training_busy === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL train_start: training_busy=%b within 10 cycles, want 1", training_busy);
    end
    repeat (100) @(posedge clk);
    #1;
    checks++;
    if (training_busy !== 1'b1 || tx_data !== {NL{12'h3A5}} || tx_lval !== 1'b0) begin
      errors++; $display("FAIL train_word: busy=%b data=%h lval=%b, want 1/lanes 3A5/0", training_busy, tx_data, tx_lval);
    end
    eds_power_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (training_busy !== 1'b1 || tx_data !== {NL{12'h3A5}}) begin
      errors++; $display("FAIL pwr_sync_latency: busy=%b data=%h, want still training", training_busy, tx_data);
    end
    @(posedge clk); #1;
    checks++;
    if (training_busy !== 1'b0 || tx_data !== '0 || tx_lval !== 1'b0 || sif.s_ready !== 1'b0) begin
      errors++; $display("FAIL pwr_off: busy=%b data=%h lval=%b rdy=%b, want all zero",
                         training_busy, tx_data, tx_lval, sif.s_ready);
    end
    checks++;
    if (line_cnt !== 16'd5 || marker_err !== 1'b1 || underrun_err !== 1'b1) begin
      errors++; $display("FAIL pwr_held: lines=%0d merr=%b uerr=%b, want 5/1/1", line_cnt, marker_err, underrun_err);
    end
    eds_power_en = 1'b1;
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
      if (training_busy === 1'b1) seen = 1;
    end
    checks++;
    if (seen || tx_data !== {NL{12'h3A5}}) begin
      errors++; $display("FAIL pwr_restore: busy_seen=%b data=%h, want no training and lanes 3A5", seen, tx_data);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_line();
    test_underrun();
    test_clip();
    test_marker();
    test_training_power();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
